// File: rtl/swap_mestre.sv
`default_nettype none
// ============================================================================
// Module   : swap_mestre
// Purpose  : Initiator for the three-register swap engine's x/done handshake.
//            On an accepted start it issues n_swaps back-to-back swap
//            requests on x. For each request it waits for the engine's
//            one-cycle done and counts completed swaps. It signals the end
//            of a run with a one-cycle finished pulse, and raises a sticky
//            err if the engine does not answer within TIMEOUT cycles.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-low reset
//            start     - run command, sampled in IDLE or ERR
//            n_swaps   - swap count for the run, latched on accepted start
//            done      - one-cycle completion from the swap engine
//            x         - swap request, high one cycle per swap
//            busy      - high while a swap is requested or awaited
//            count     - swaps completed in the current or last run
//            finished  - one-cycle pulse at the end of a run
//            err       - timeout flag, held until the next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module swap_mestre #(
    parameter int CW      = 8,
    parameter int TW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] n_swaps,
    input  logic          done,
    output logic          x,
    output logic          busy,
    output logic [CW-1:0] count,
    output logic          finished,
    output logic          err
);

    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FIN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] n_lat;
    logic [CW-1:0] n_next;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_inc;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_next;
    logic [TW-1:0] tcnt_inc;

    assign count_inc = count + CW'(1);
    assign tcnt_inc  = tcnt + TW'(1);

    // Next-state and datapath update.
    always_comb begin
        state_next = state;
        n_next     = n_lat;
        count_next = count;
        tcnt_next  = tcnt;
        case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    n_next     = n_swaps;
                    count_next = '0;
                    tcnt_next  = '0;
                    state_next = (n_swaps == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                tcnt_next  = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the timeout cycle still completes the swap.
                if (done) begin
                    count_next = count_inc;
                    state_next = (count_inc == n_lat) ? S_FIN : S_REQ;
                end else begin
                    tcnt_next = tcnt_inc;
                    if (tcnt_inc == TO_LIMIT) begin
                        state_next = S_ERR;
                    end
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            n_lat <= '0;
            count <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_next;
            n_lat <= n_next;
            count <= count_next;
            tcnt  <= tcnt_next;
        end
    end

    // Outputs are registered from the next state, so each flag is high
    // exactly while the FSM occupies the corresponding state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x        <= 1'b0;
            busy     <= 1'b0;
            finished <= 1'b0;
            err      <= 1'b0;
        end else begin
            x        <= (state_next == S_REQ);
            busy     <= (state_next == S_REQ) || (state_next == S_WAIT);
            finished <= (state_next == S_FIN);
            err      <= (state_next == S_ERR);
        end
    end

endmodule
`default_nettype wire
